// File: rtl/bitmask_index_scheduler.sv
// Walks a bit mask lowest-index-first, emitting one beat per set bit for the shift-add accumulator.
// Build option: define SCHED_SKIP_ZERO_EN to swallow all-zero masks instead of emitting a single zero-flagged beat.
module bitmask_index_scheduler #(
   parameter int MASK_W = 16,
   parameter int IDX_W  = $clog2(MASK_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MASK_W-1:0] in_mask,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_idx,
   output logic              out_last,
   output logic              out_zero,
   output logic [IDX_W:0]    out_seq
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, state_next;
   logic [MASK_W-1:0] work, work_next;
   logic [IDX_W:0]    seq, seq_next;
   logic              zflag, zflag_next;
   logic [IDX_W-1:0]  low_idx;
   logic              single;
   logic              active;
   logic              in_fire;
   logic              out_fire;

   // Scanning from the top down lets the lowest set bit win the priority.
   always_comb begin
      low_idx = '0;
      for (int i = MASK_W - 1; i >= 0; i--) begin
         if (work[i]) begin
            low_idx = IDX_W'(i);
         end
      end
   end

   assign single = ((work & (work - MASK_W'(1))) == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         work  <= '0;
         seq   <= '0;
         zflag <= 1'b0;
      end else begin
         state <= state_next;
         work  <= work_next;
         seq   <= seq_next;
         zflag <= zflag_next;
      end
   end

   // A new mask may load in the same cycle the final beat of the old one retires.
   always_comb begin
      state_next = state;
      work_next  = work;
      seq_next   = seq;
      zflag_next = zflag;
      if (out_fire) begin
         if (!out_last) begin
            work_next = work & ~(MASK_W'(1) << low_idx);
            seq_next  = seq + (IDX_W + 1)'(1);
         end else begin
            work_next  = '0;
            zflag_next = 1'b0;
            state_next = IDLE;
         end
      end
      if (in_fire) begin
`ifdef SCHED_SKIP_ZERO_EN
         if (in_mask != '0) begin
            work_next  = in_mask;
            seq_next   = '0;
            zflag_next = 1'b0;
            state_next = RUN;
         end
`else
         work_next  = in_mask;
         seq_next   = '0;
         zflag_next = (in_mask == '0);
         state_next = RUN;
`endif
      end
   end

   always_comb begin
      active    = (state == RUN) && !reset;
      out_valid = active;
      out_idx   = active ? low_idx : '0;
      out_last  = active & single;
      out_zero  = active & zflag;
      out_seq   = active ? seq : '0;
      out_fire  = out_valid & out_ready;
      in_ready  = !reset & ((state == IDLE) | (out_fire & out_last));
      in_fire   = in_valid & in_ready;
   end

endmodule

// File: tb/tb_bitmask_index_scheduler.sv
// Bench for bitmask_index_scheduler: vector table plus hand sequences, checked through a beat scoreboard.
module tb_bitmask_index_scheduler;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_mask;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_idx;
   logic        out_last;
   logic        out_zero;
   logic [4:0]  out_seq;

   typedef struct packed {
      logic [3:0] idx;
      logic       last;
      logic       zero;
      logic [4:0] seq;
   } beat_t;

   typedef struct {
      logic [15:0] mask;
      int          beats;
      logic [3:0]  last_idx;
   } vec_t;

   beat_t sb[$];
   vec_t  vecs[7];
   int    compared;
   int    mismatched;
   int    cyc;
   int    beat_count;
   int    first_cyc;
   int    last_cyc;
   int    accept_cyc;
   int    accept_first;
   logic [3:0] last_idx_seen;

   bitmask_index_scheduler #(.MASK_W(16), .IDX_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mask   (in_mask),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_zero  (out_zero),
      .out_seq   (out_seq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: ascending scan of the mask, independent of the DUT's priority logic.
   task automatic pushModel(input logic [15:0] mask);
      int n;
      int s;
      beat_t b;
      n = $countones(mask);
      s = 0;
      if (mask == 16'h0000) begin
         b = '{idx: 4'd0, last: 1'b1, zero: 1'b1, seq: 5'd0};
         sb.push_back(b);
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (mask[i]) begin
               b = '{idx: 4'(i), last: (s == n - 1), zero: 1'b0, seq: 5'(s)};
               sb.push_back(b);
               s++;
            end
         end
      end
   endtask

   task automatic clearStats();
      beat_count    = 0;
      first_cyc     = -1;
      last_cyc      = -1;
      last_idx_seen = 4'd0;
   endtask

   // Called just after a posedge; returns just after the posedge that accepts the mask.
   task automatic applyStimulus(input logic [15:0] mask);
      bit accepted;
      accepted = 1'b0;
      in_valid = 1'b1;
      in_mask  = mask;
      for (int i = 0; i < 50 && !accepted; i++) begin
         @(negedge clk);
         if (in_ready) begin
            accepted   = 1'b1;
            accept_cyc = cyc;
            pushModel(mask);
         end
      end
      checkOutput("accept", {31'd0, accepted}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) begin
         @(negedge clk);
      end
      checkOutput("drain", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checkOutput("no_beat_expected", {31'd0, out_valid}, 32'd0);
         end else begin
            checkOutput("beat", {out_idx, out_last, out_zero, out_seq}, sb.pop_front());
         end
         if (beat_count == 0) first_cyc = cyc;
         last_cyc      = cyc;
         last_idx_seen = out_idx;
         beat_count++;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      in_valid   = 1'b0;
      in_mask    = 16'h0000;
      out_ready  = 1'b1;
      clearStats();

      vecs[0] = '{16'h8421, 4, 4'd15};
      vecs[1] = '{16'h0000, 1, 4'd0};
      vecs[2] = '{16'hFFFF, 16, 4'd15};
      vecs[3] = '{16'h0001, 1, 4'd0};
      vecs[4] = '{16'h8000, 1, 4'd15};
      vecs[5] = '{16'h00F0, 4, 4'd7};
      vecs[6] = '{16'h5555, 8, 4'd14};

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("idle_outputs", {out_valid, out_idx, out_last, out_zero, out_seq}, 12'd0);
      @(posedge clk);
      #1;

      // Table-driven single masks with the consumer always ready.
      for (int v = 0; v < 7; v++) begin
         clearStats();
         applyStimulus(vecs[v].mask);
         waitDrain();
         checkOutput($sformatf("v%0d_count", v), beat_count, vecs[v].beats);
         checkOutput($sformatf("v%0d_last_idx", v), {28'd0, last_idx_seen}, {28'd0, vecs[v].last_idx});
         checkOutput($sformatf("v%0d_span", v), last_cyc - first_cyc, vecs[v].beats - 1);
         checkOutput($sformatf("v%0d_latency", v), first_cyc, accept_cyc + 1);
      end

      // Back-to-back masks: second one accepted while the final beat of the first retires.
      clearStats();
      applyStimulus(16'h0003);
      applyStimulus(16'h0100);
      accept_first = accept_cyc;
      waitDrain();
      checkOutput("b2b_count", beat_count, 3);
      checkOutput("b2b_span", last_cyc - first_cyc, 2);
      checkOutput("b2b_accept_cycle", accept_first, first_cyc + 1);

      // Consumer stall: the first beat must hold steady while out_ready is low.
      clearStats();
      out_ready = 1'b0;
      applyStimulus(16'h0081);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput($sformatf("stall_hold%0d", i), {out_valid, out_idx, out_last, out_seq}, {1'b1, 4'd0, 1'b0, 5'd0});
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      waitDrain();
      checkOutput("stall_count", beat_count, 2);
      checkOutput("stall_last_idx", {28'd0, last_idx_seen}, 32'd7);

      // Reset mid-run discards the rest of the mask.
      clearStats();
      applyStimulus(16'h00F0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("postrst_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("postrst_out_valid", {31'd0, out_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput($sformatf("postrst_quiet%0d", i), {31'd0, out_valid}, 32'd0);
      end
      checkOutput("midrst_beats", beat_count, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
